// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue/writeback stage.
package alu_pkg;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    typedef struct packed {
        logic cflag;
        logic sum_en;
        logic and_en;
        logic xor_en;
        logic invb_en;
        logic lsh_en;
        logic rsh_en;
        logic ltu_en;
        logic lts_en;
    } alu_strobe_t;

    localparam alu_strobe_t STROBE_NONE = '{default: 1'b0};

    // Ops that have a 32-bit (W) form.
    function automatic logic w_op_legal(input logic [3:0] code);
        case (code)
            OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA: w_op_legal = 1'b1;
            default:                                w_op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Op-in / result-out handshake bundle of the issue stage.
interface alu_issue_if;
    import alu_pkg::*;

    logic             op_valid_i;
    logic             op_ready_o;
    logic [3:0]       op_code_i;
    logic             op_w_i;
    logic [XLEN-1:0]  op_a_i;
    logic [XLEN-1:0]  op_b_i;
    logic [TAG_W-1:0] op_rd_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [XLEN-1:0]  res_data_o;
    logic [TAG_W-1:0] res_rd_o;
    logic             res_ill_o;

    modport slave (
        input  op_valid_i, op_code_i, op_w_i, op_a_i, op_b_i, op_rd_i, res_ready_i,
        output op_ready_o, res_valid_o, res_data_o, res_rd_o, res_ill_o
    );

    modport master (
        output op_valid_i, op_code_i, op_w_i, op_a_i, op_b_i, op_rd_i, res_ready_i,
        input  op_ready_o, res_valid_o, res_data_o, res_rd_o, res_ill_o
    );

endinterface

// File: rtl/alu_issue_decode.sv
// Op code (+ W flag when ALU_OPW_EN is defined) to ALU strobe bundle and illegal flag.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [3:0]  i_op_code,
`ifdef ALU_OPW_EN
    input  logic        i_op_w,
`endif
    output alu_strobe_t o_strobe,
    output logic        o_ill
);

    // Strobe table; OR uses and+xor since the ALU ORs its terms together.
    always_comb begin
        o_strobe = STROBE_NONE;
        o_ill    = 1'b0;
        case (i_op_code)
            OP_ADD:  o_strobe.sum_en = 1'b1;
            OP_SUB:  begin o_strobe.sum_en = 1'b1; o_strobe.invb_en = 1'b1; o_strobe.cflag = 1'b1; end
            OP_SLL:  o_strobe.lsh_en = 1'b1;
            OP_SRL:  o_strobe.rsh_en = 1'b1;
            OP_SRA:  begin o_strobe.rsh_en = 1'b1; o_strobe.cflag = 1'b1; end
            OP_XOR:  o_strobe.xor_en = 1'b1;
            OP_AND:  o_strobe.and_en = 1'b1;
            OP_OR:   begin o_strobe.and_en = 1'b1; o_strobe.xor_en = 1'b1; end
            OP_SLT:  begin o_strobe.lts_en = 1'b1; o_strobe.sum_en = 1'b1;
                           o_strobe.invb_en = 1'b1; o_strobe.cflag = 1'b1; end
            OP_SLTU: begin o_strobe.ltu_en = 1'b1; o_strobe.sum_en = 1'b1;
                           o_strobe.invb_en = 1'b1; o_strobe.cflag = 1'b1; end
            default: o_ill = 1'b1;
        endcase
`ifdef ALU_OPW_EN
        if (i_op_w && !w_op_legal(i_op_code)) begin
            o_ill = 1'b1;
        end else begin
            o_ill = o_ill;
        end
`endif
    end

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue (E1) / writeback (WB) wrapper around an external 64-bit ALU.
// Optional 32-bit op support is enabled by defining ALU_OPW_EN.
module alu_issue
    import alu_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    alu_issue_if.slave       bus,
    output logic [XLEN-1:0]  alu_a_o,
    output logic [XLEN-1:0]  alu_b_o,
    output logic             alu_cflag_o,
    output logic             alu_sum_en_o,
    output logic             alu_and_en_o,
    output logic             alu_xor_en_o,
    output logic             alu_invb_en_o,
    output logic             alu_lsh_en_o,
    output logic             alu_rsh_en_o,
    output logic             alu_ltu_en_o,
    output logic             alu_lts_en_o,
    input  logic [XLEN-1:0]  alu_out_i
);

    logic             r_e1_valid;
    logic [3:0]       r_e1_code;
    logic [XLEN-1:0]  r_e1_a;
    logic [XLEN-1:0]  r_e1_b;
    logic [TAG_W-1:0] r_e1_rd;
    logic             r_res_valid;
    logic [XLEN-1:0]  r_res_data;
    logic [TAG_W-1:0] r_res_rd;
    logic             r_res_ill;

    logic             w_advance;
    logic             w_op_ready;
    logic             w_accept;
    logic [XLEN-1:0]  w_load_a;
    logic [XLEN-1:0]  w_load_b;
    logic [XLEN-1:0]  w_wb_data;
    logic             w_ill;
    alu_strobe_t      w_strobe;
    alu_strobe_t      w_strobe_g;

    assign w_advance  = ~r_res_valid | bus.res_ready_i;
    assign w_op_ready = ~flush_i & (~r_e1_valid | w_advance);
    assign w_accept   = bus.op_valid_i & w_op_ready;

`ifdef ALU_OPW_EN
    logic r_e1_w;

    // W shifts use a 5-bit amount and a 32-bit source extended to suit the shift kind.
    always_comb begin
        w_load_a = bus.op_a_i;
        w_load_b = bus.op_b_i;
        if (bus.op_w_i && (bus.op_code_i == OP_SLL || bus.op_code_i == OP_SRL ||
                           bus.op_code_i == OP_SRA)) begin
            w_load_b = {{(XLEN-5){1'b0}}, bus.op_b_i[4:0]};
            if (bus.op_code_i == OP_SRL) begin
                w_load_a = {32'd0, bus.op_a_i[31:0]};
            end else if (bus.op_code_i == OP_SRA) begin
                w_load_a = {{32{bus.op_a_i[31]}}, bus.op_a_i[31:0]};
            end else begin
                w_load_a = bus.op_a_i;
            end
        end else begin
            w_load_b = bus.op_b_i;
        end
    end

    assign w_wb_data = w_ill  ? {XLEN{1'b0}} :
                       r_e1_w ? {{32{alu_out_i[31]}}, alu_out_i[31:0]} : alu_out_i;

    // W flag travels with the op in E1.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_e1_w <= 1'b0;
        end else if (w_accept) begin
            r_e1_w <= bus.op_w_i;
        end
    end
`else
    assign w_load_a  = bus.op_a_i;
    assign w_load_b  = bus.op_b_i;
    assign w_wb_data = w_ill ? {XLEN{1'b0}} : alu_out_i;
`endif

    alu_issue_decode u_decode (
        .i_op_code (r_e1_code),
`ifdef ALU_OPW_EN
        .i_op_w    (r_e1_w),
`endif
        .o_strobe  (w_strobe),
        .o_ill     (w_ill)
    );

    // E1: operands stay put when empty so the ALU inputs never toggle needlessly.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_e1_valid <= 1'b0;
            r_e1_code  <= 4'd0;
            r_e1_a     <= {XLEN{1'b0}};
            r_e1_b     <= {XLEN{1'b0}};
            r_e1_rd    <= {TAG_W{1'b0}};
        end else if (flush_i) begin
            r_e1_valid <= 1'b0;
        end else if (w_accept) begin
            r_e1_valid <= 1'b1;
            r_e1_code  <= bus.op_code_i;
            r_e1_a     <= w_load_a;
            r_e1_b     <= w_load_b;
            r_e1_rd    <= bus.op_rd_i;
        end else if (r_e1_valid && w_advance) begin
            r_e1_valid <= 1'b0;
        end
    end

    // WB: captures the ALU result; holds while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_res_valid <= 1'b0;
            r_res_data  <= {XLEN{1'b0}};
            r_res_rd    <= {TAG_W{1'b0}};
            r_res_ill   <= 1'b0;
        end else if (flush_i) begin
            r_res_valid <= 1'b0;
        end else if (r_e1_valid && w_advance) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_wb_data;
            r_res_rd    <= r_e1_rd;
            r_res_ill   <= w_ill;
        end else if (bus.res_ready_i) begin
            r_res_valid <= 1'b0;
        end
    end

    assign w_strobe_g = (r_e1_valid && !w_ill) ? w_strobe : STROBE_NONE;

    assign bus.op_ready_o  = w_op_ready;
    assign bus.res_valid_o = r_res_valid;
    assign bus.res_data_o  = r_res_data;
    assign bus.res_rd_o    = r_res_rd;
    assign bus.res_ill_o   = r_res_ill;

    assign alu_a_o       = r_e1_a;
    assign alu_b_o       = r_e1_b;
    assign alu_cflag_o   = w_strobe_g.cflag;
    assign alu_sum_en_o  = w_strobe_g.sum_en;
    assign alu_and_en_o  = w_strobe_g.and_en;
    assign alu_xor_en_o  = w_strobe_g.xor_en;
    assign alu_invb_en_o = w_strobe_g.invb_en;
    assign alu_lsh_en_o  = w_strobe_g.lsh_en;
    assign alu_rsh_en_o  = w_strobe_g.rsh_en;
    assign alu_ltu_en_o  = w_strobe_g.ltu_en;
    assign alu_lts_en_o  = w_strobe_g.lts_en;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: strobe-driven ALU model, op-level reference model and result scoreboard.
module tb_alu_issue;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [63:0] alu_a, alu_b, alu_out;
    logic        s_cflag, s_sum, s_and, s_xor, s_invb, s_lsh, s_rsh, s_ltu, s_lts;
    logic [8:0]  stb;
    logic [69:0] q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_taken = 0;

    alu_issue_if bus ();

    always #5 clk = ~clk;

    alu_issue dut (
        .clk_i(clk), .reset_i(reset), .flush_i(flush), .bus(bus),
        .alu_a_o(alu_a), .alu_b_o(alu_b),
        .alu_cflag_o(s_cflag), .alu_sum_en_o(s_sum), .alu_and_en_o(s_and),
        .alu_xor_en_o(s_xor), .alu_invb_en_o(s_invb), .alu_lsh_en_o(s_lsh),
        .alu_rsh_en_o(s_rsh), .alu_ltu_en_o(s_ltu), .alu_lts_en_o(s_lts),
        .alu_out_i(alu_out)
    );

    assign stb = {s_cflag, s_sum, s_and, s_xor, s_invb, s_lsh, s_rsh, s_ltu, s_lts};

    // ALU behaviour: comparators override, otherwise enabled terms are ORed.
    always_comb begin
        alu_out = 64'd0;
        if (s_lts) alu_out = {63'd0, $signed(alu_a) < $signed(alu_b)};
        else if (s_ltu) alu_out = {63'd0, alu_a < alu_b};
        else begin
            if (s_sum) alu_out = alu_out | (alu_a + (s_invb ? ~alu_b : alu_b) + {63'd0, s_cflag});
            if (s_and) alu_out = alu_out | (alu_a & alu_b);
            if (s_xor) alu_out = alu_out | (alu_a ^ alu_b);
            if (s_lsh) alu_out = alu_out | (alu_a << alu_b[5:0]);
            if (s_rsh) alu_out = alu_out | (s_cflag ? 64'($signed(alu_a) >>> alu_b[5:0])
                                                    : (alu_a >> alu_b[5:0]));
        end
    end

    // Architectural result of one op: {ill, data}.
    function automatic logic [64:0] ref_op(input logic [3:0] c, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic        ill;
        logic [31:0] r32;
        ill = 1'b0;
        r   = 64'd0;
        r32 = 32'd0;
`ifdef ALU_OPW_EN
        if (w) begin
            case (c)
                4'd0: r32 = a[31:0] + b[31:0];
                4'd1: r32 = a[31:0] - b[31:0];
                4'd2: r32 = a[31:0] << b[4:0];
                4'd6: r32 = a[31:0] >> b[4:0];
                4'd7: r32 = 32'($signed(a[31:0]) >>> b[4:0]);
                default: ill = 1'b1;
            endcase
            r = {{32{r32[31]}}, r32};
        end else
`endif
        begin
            case (c)
                4'd0: r = a + b;
                4'd1: r = a - b;
                4'd2: r = a << b[5:0];
                4'd3: r = {63'd0, $signed(a) < $signed(b)};
                4'd4: r = {63'd0, a < b};
                4'd5: r = a ^ b;
                4'd6: r = a >> b[5:0];
                4'd7: r = 64'($signed(a) >>> b[5:0]);
                4'd8: r = a | b;
                4'd9: r = a & b;
                default: ill = 1'b1;
            endcase
        end
        if (ill) r = 64'd0;
        return {ill, r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check ready and any result handshake, then advance the model at the edge.
    task automatic tick(output logic acc);
        logic        take;
        logic        exp_rdy;
        logic [64:0] r;
        logic [69:0] e;
        #1;
        exp_rdy = !flush && !(q.size() == 2 && !bus.res_ready_i);
        chk("op_ready", 64'(bus.op_ready_o), 64'(exp_rdy));
        acc  = bus.op_valid_i && bus.op_ready_o;
        take = bus.res_valid_o && bus.res_ready_i;
        if (q.size() == 0) begin
            chk("res_valid_idle", 64'(bus.res_valid_o), 64'd0);
        end else if (take) begin
            e = q[0];
            chk("res_data", bus.res_data_o, e[63:0]);
            chk("res_rd", 64'(bus.res_rd_o), 64'(e[68:64]));
            chk("res_ill", 64'(bus.res_ill_o), 64'(e[69]));
            n_taken++;
        end
        r = ref_op(bus.op_code_i, bus.op_w_i, bus.op_a_i, bus.op_b_i);
        @(posedge clk);
        if (reset || flush) begin
            q.delete();
        end else begin
            if (take && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back({r[64], bus.op_rd_i, r[63:0]});
        end
        @(negedge clk);
    endtask

    task automatic set_op(input logic [3:0] c, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd);
        bus.op_code_i = c; bus.op_w_i = w; bus.op_a_i = a; bus.op_b_i = b; bus.op_rd_i = rd;
    endtask

    task automatic directed(input string tag, input logic [3:0] c, input logic w,
                            input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                            input logic [8:0] exp_stb, input logic [63:0] exp_data,
                            input logic exp_ill);
        logic acc;
        set_op(c, w, a, b, rd);
        bus.op_valid_i = 1'b1; bus.res_ready_i = 1'b1;
        tick(acc);
        bus.op_valid_i = 1'b0;
        chk({tag, "_acc"}, 64'(acc), 64'd1);
        chk({tag, "_stb"}, 64'(stb), 64'(exp_stb));
        tick(acc);
        chk({tag, "_valid"}, 64'(bus.res_valid_o), 64'd1);
        chk({tag, "_data"}, bus.res_data_o, exp_data);
        chk({tag, "_rd"}, 64'(bus.res_rd_o), 64'(rd));
        chk({tag, "_ill"}, 64'(bus.res_ill_o), 64'(exp_ill));
        tick(acc);
    endtask

    task automatic drain();
        logic acc;
        bus.op_valid_i = 1'b0; bus.res_ready_i = 1'b1; flush = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) tick(acc);
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic acc;
        int   sent;
        int   taken0;
        reset = 1'b1; flush = 1'b0;
        bus.op_valid_i = 1'b0; bus.res_ready_i = 1'b1;
        set_op(4'd0, 1'b0, 64'd0, 64'd0, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_res_valid", 64'(bus.res_valid_o), 64'd0);
        chk("rst_res_data", bus.res_data_o, 64'd0);
        chk("rst_res_rd", 64'(bus.res_rd_o), 64'd0);
        chk("rst_res_ill", 64'(bus.res_ill_o), 64'd0);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_alu_b", alu_b, 64'd0);
        chk("rst_stb", 64'(stb), 64'd0);
        chk("rst_ready", 64'(bus.op_ready_o), 64'd1);
        reset = 1'b0;

        directed("sub", 4'd1, 1'b0, 64'd5, 64'd7, 5'd3, 9'b110010000, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        directed("or", 4'd8, 1'b0, 64'hF0, 64'h0F, 5'd9, 9'b001100000, 64'hFF, 1'b0);
        directed("sltu", 4'd4, 1'b0, 64'd1, 64'd2, 5'd17, 9'b110010010, 64'd1, 1'b0);
        directed("slt", 4'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd31, 9'b110010001, 64'd1, 1'b0);
        directed("ill12", 4'd12, 1'b0, 64'd123, 64'd456, 5'd4, 9'b000000000, 64'd0, 1'b1);
        directed("sra", 4'd7, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'd6, 9'b100000100,
                 64'hF800_0000_0000_0000, 1'b0);
`ifdef ALU_OPW_EN
        directed("addw", 4'd0, 1'b1, 64'h7FFF_FFFF, 64'd1, 5'd2, 9'b010000000,
                 64'hFFFF_FFFF_8000_0000, 1'b0);
        directed("sraw", 4'd7, 1'b1, 64'h8000_0000, 64'd4, 5'd5, 9'b100000100,
                 64'hFFFF_FFFF_F800_0000, 1'b0);
        directed("xorw", 4'd5, 1'b1, 64'd3, 64'd5, 5'd7, 9'b000000000, 64'd0, 1'b1);
`else
        directed("addw", 4'd0, 1'b1, 64'h7FFF_FFFF, 64'd1, 5'd2, 9'b010000000,
                 64'h0000_0000_8000_0000, 1'b0);
`endif

        // 8 back-to-back ADDs with a 3-cycle consumer stall mid-stream.
        sent = 0; taken0 = n_taken;
        for (int i = 0; i < 40 && (sent < 8 || q.size() > 0); i++) begin
            bus.op_valid_i = (sent < 8);
            set_op(4'd0, 1'b0, 64'(sent) * 64'd1000, 64'(sent) + 64'd1, 5'(sent + 10));
            bus.res_ready_i = !(i >= 3 && i <= 5);
            tick(acc);
            if (acc) sent++;
        end
        chk("b2b_sent", 64'(sent), 64'd8);
        chk("b2b_taken", 64'(n_taken - taken0), 64'd8);

        // Flush with both stages full and a new op on offer.
        bus.res_ready_i = 1'b0; bus.op_valid_i = 1'b1;
        set_op(4'd0, 1'b0, 64'd1, 64'd2, 5'd1);
        tick(acc);
        set_op(4'd5, 1'b0, 64'd3, 64'd4, 5'd2);
        tick(acc);
        chk("fl_wb_full", 64'(bus.res_valid_o), 64'd1);
        set_op(4'd9, 1'b0, 64'd5, 64'd6, 5'd3);
        flush = 1'b1;
        tick(acc);
        chk("fl_no_accept", 64'(acc), 64'd0);
        flush = 1'b0; bus.op_valid_i = 1'b0;
        #1;
        chk("fl_res_valid", 64'(bus.res_valid_o), 64'd0);
        chk("fl_ready", 64'(bus.op_ready_o), 64'd1);
        bus.res_ready_i = 1'b1;
        repeat (3) tick(acc);

        // Reset (with flush) mid-operation drops everything.
        bus.res_ready_i = 1'b0; bus.op_valid_i = 1'b1;
        set_op(4'd1, 1'b0, 64'd9, 64'd1, 5'd8);
        repeat (2) tick(acc);
        reset = 1'b1; flush = 1'b1;
        tick(acc);
        reset = 1'b0; flush = 1'b0; bus.op_valid_i = 1'b0; bus.res_ready_i = 1'b1;
        #1;
        chk("rm_res_valid", 64'(bus.res_valid_o), 64'd0);
        chk("rm_res_data", bus.res_data_o, 64'd0);
        chk("rm_alu_a", alu_a, 64'd0);
        repeat (3) tick(acc);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            bus.op_valid_i = ($urandom_range(0, 3) != 0);
            set_op(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9)),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 80)),
                   ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 70)),
                   5'($urandom_range(0, 31)));
            flush = ($urandom_range(0, 31) == 0);
            bus.res_ready_i = flush ? 1'b0 : ($urandom_range(0, 2) != 0);
            tick(acc);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue/writeback stage wrapped around the 64-bit ALU. Accepts decoded integer ops from decode over a valid/ready handshake and registers operands in stage E1. Drives the ALU's operand and enable strobes from E1, then captures the ALU result into a writeback register (WB) offered downstream over a second valid/ready handshake. Two-stage pipeline, one op per cycle sustained, with a synchronous flush for branch/trap kills.

## Interface
- No parameters; widths fixed (XLEN 64, tag 5).
- clk_i  in  1  clock; all state updates on the rising edge
- reset_i  in  1  synchronous, active-high reset
- flush_i  in  1  kill E1 and WB contents this edge
- op_valid_i  in  1  decode offers an op
- op_ready_o  out  1  stage can accept
- op_code_i  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10-15 illegal
- op_w_i  in  1  32-bit (W) variant
- op_a_i, op_b_i  in  64  operands
- op_rd_i  in  5  destination tag
- alu_a_o, alu_b_o  out  64  to ALU inA/inB
- alu_cflag_o, alu_sum_en_o, alu_and_en_o, alu_xor_en_o, alu_invb_en_o, alu_lsh_en_o, alu_rsh_en_o, alu_ltu_en_o, alu_lts_en_o  out  1  ALU strobes
- alu_out_i  in  64  ALU result
- res_valid_o  out  1  WB holds a result
- res_ready_i  in  1  consumer takes result
- res_data_o  out  64  result
- res_rd_o  out  5  tag
- res_ill_o  out  1  op was illegal; res_data_o = 0

## Operation
- Strobe decode: ADD sum. SUB sum+invB+cflag. SLL lsh. SRL rsh. SRA rsh+cflag. XOR xor. AND and. OR and+xor (ALU ORs terms: (A&B)|(A^B) = A|B). SLT lts+sum+invB+cflag. SLTU ltu+sum+invB+cflag.
- Strobes are decoded from E1 and forced to 0 whenever E1 is empty or E1 holds an illegal op.
- alu_a_o/alu_b_o are the E1 operand registers and hold their value when E1 is empty.
- advance = ~res_valid_o | res_ready_i. op_ready_o = ~flush_i & (~e1_valid | advance).
- E1 loads on op_valid_i & op_ready_o. WB loads from E1 and the ALU on e1_valid & advance. E1 clears when it advances without a refill.
- Illegal op: flows through normally. WB captures data 0 and ill 1.
- flush_i: e1_valid and res_valid_o clear at the edge. No op is accepted that cycle. Flush beats every other event.
- Stalled WB (res_valid_o & ~res_ready_i): WB contents, E1 contents and the ALU drive are frozen.

## Timing
- Accept at edge k, result valid after edge k+1. Latency 2 edges, throughput 1 op per cycle.
- ALU is combinational between E1 and WB; nothing else sits in that path.
- op_ready_o is combinational from res_ready_i and flush_i. No other combinational input-to-output paths.
- Reset values: res_valid_o 0, res_data_o 0, res_rd_o 0, res_ill_o 0, E1 empty, alu_a_o/alu_b_o 0, all strobes 0, op_ready_o 1 (with flush_i low).
- Reset mid-operation discards both stages with no result emitted. Reset dominates flush.

## Configuration
- ALU_OPW_EN defined: op_w_i is legal only with ADD, SUB, SLL, SRL, SRA; any other op with op_w_i=1 is illegal.
  - At E1 load, shift amount is masked to b[4:0]. SRLW zero-extends a[31:0]; SRAW sign-extends a[31:0].
  - At WB, the result is {32{alu_out_i[31]}, alu_out_i[31:0]}.
- ALU_OPW_EN undefined: op_w_i is ignored and every op executes as 64-bit.

## Structure
- alu_pkg: op-code constants, XLEN=64, TAG_W=5, strobe bundle struct.
- Sub-module alu_issue_decode: combinational op_code plus w to strobe bundle and illegal flag, instantiated on E1.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- SUB a=5, b=7 -> strobes sum/invB/cflag; 2 edges later res_data_o=0xFFFF_FFFF_FFFF_FFFE, rd passed through.
- OR a=0xF0, b=0x0F -> and+xor strobes; res_data_o=0xFF. SLTU a=1, b=2 -> 1. SLT a=-1, b=1 -> 1.
- Back-to-back 8 ADDs with res_ready_i low for 3 cycles mid-stream -> no loss, no duplication, order kept, op_ready_o low only while both stages full.
- flush_i while E1 and WB both full and op_valid_i=1 -> next cycle res_valid_o=0, nothing accepted, op_ready_o=1.
- op_code 12 -> res_ill_o=1, res_data_o=0, all ALU strobes 0 during E1.
- ALU_OPW_EN: SRAW a=0x8000_0000, b=4 -> 0xFFFF_FFFF_F800_0000. ADDW 0x7FFF_FFFF+1 -> 0xFFFF_FFFF_8000_0000. XOR with w -> illegal. Without the macro, ADD with w=1 -> 0x8000_0000.
